pwm_alarm_ctrl: RTL and testbench

- Duty-cycle controller that sits in front of the pwm block and decides which duty value it receives.
- Idle: passes the manual (button-driven) duty through.
- Alarm: runs a beep pattern of ON/OFF bursts whose duty ramps up each burst, with acknowledge and snooze.
- Output duty_cmd drives the PWM duty input directly.

---
 rtl/pwm_alarm_ctrl.sv | 145 ++++++++++++++
 tb/tb_pwm_alarm_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_alarm_ctrl.sv
// Duty-cycle selector in front of the pwm block: manual duty when idle, ramped
// beep bursts with acknowledge and snooze while an alarm is running.
module pwm_alarm_ctrl #(
    parameter int DUTY_MAX     = 100,
    parameter int TICK_DIV     = 100000,
    parameter int ON_TICKS     = 200,
    parameter int OFF_TICKS    = 200,
    parameter int SNOOZE_TICKS = 5000,
    parameter int RAMP_STEP    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] manual_duty,
    input  logic       trigger,
    input  logic       ack,
    input  logic       snooze,
    output logic [6:0] duty_cmd,
    output logic       alarm_active,
    output logic [1:0] state,
    output logic [7:0] burst_cnt
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ?
        ((ON_TICKS > SNOOZE_TICKS) ? ON_TICKS : SNOOZE_TICKS) :
        ((OFF_TICKS > SNOOZE_TICKS) ? OFF_TICKS : SNOOZE_TICKS);
    localparam int DW = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;
    localparam logic [6:0] DMAX  = 7'(DUTY_MAX);
    localparam logic [6:0] RSTEP = 7'(RAMP_STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ON     = 2'd1,
        S_OFF    = 2'd2,
        S_SNOOZE = 2'd3
    } state_t;

    state_t        cur;
    logic [PW-1:0] prescaler;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_last;
    logic [6:0]    level;
    logic          trigger_d;

    logic       tick;
    logic       expire;
    logic       trig_rise;
    logic [6:0] cmanual;
    logic [7:0] level_sum;
    logic [6:0] level_next;
    logic [7:0] burst_inc;

    assign state     = cur;
    assign cmanual   = (manual_duty > DMAX) ? DMAX : manual_duty;
    assign tick      = (prescaler == PW'(TICK_DIV - 1));
    assign trig_rise = trigger & ~trigger_d;
    // Sum is 8 bits wide so a large level plus step cannot wrap before the clamp.
    assign level_sum  = {1'b0, level} + {1'b0, RSTEP};
    assign level_next = (level_sum > {1'b0, DMAX}) ? DMAX : level_sum[6:0];
    assign burst_inc  = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
    assign expire     = tick && (dwell == dwell_last);

    always_comb begin
        dwell_last = '0;
        case (cur)
            S_ON:     dwell_last = DW'(ON_TICKS - 1);
            S_OFF:    dwell_last = DW'(OFF_TICKS - 1);
            S_SNOOZE: dwell_last = DW'(SNOOZE_TICKS - 1);
            default:  dwell_last = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur          <= S_IDLE;
            duty_cmd     <= '0;
            alarm_active <= 1'b0;
            burst_cnt    <= '0;
            prescaler    <= '0;
            dwell        <= '0;
            level        <= '0;
            trigger_d    <= 1'b0;
        end else begin
            trigger_d <= trigger;
            case (cur)
                S_IDLE: begin
                    duty_cmd  <= cmanual;
                    prescaler <= '0;
                    dwell     <= '0;
                    if (trig_rise && !ack) begin
                        cur          <= S_ON;
                        alarm_active <= 1'b1;
                        level        <= RSTEP;
                        duty_cmd     <= RSTEP;
                        burst_cnt    <= 8'd1;
                    end
                end
                default: begin
                    // Timed states: ack beats snooze, snooze beats timer expiry.
                    if (ack) begin
                        cur          <= S_IDLE;
                        alarm_active <= 1'b0;
                        duty_cmd     <= cmanual;
                        level        <= '0;
                        burst_cnt    <= '0;
                        prescaler    <= '0;
                        dwell        <= '0;
                    end else if (snooze && cur != S_SNOOZE) begin
                        cur       <= S_SNOOZE;
                        duty_cmd  <= '0;
                        prescaler <= '0;
                        dwell     <= '0;
                    end else if (expire) begin
                        prescaler <= '0;
                        dwell     <= '0;
                        case (cur)
                            S_ON: begin
                                cur      <= S_OFF;
                                duty_cmd <= '0;
                            end
                            S_OFF: begin
                                cur       <= S_ON;
                                level     <= level_next;
                                duty_cmd  <= level_next;
                                burst_cnt <= burst_inc;
                            end
                            default: begin
                                cur       <= S_ON;
                                level     <= RSTEP;
                                duty_cmd  <= RSTEP;
                                burst_cnt <= burst_inc;
                            end
                        endcase
                    end else if (tick) begin
                        prescaler <= '0;
                        dwell     <= dwell + 1'b1;
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_alarm_ctrl.sv
// Bench for pwm_alarm_ctrl: directed scenarios plus random traffic, checked
// against a phase/countdown model of the alarm behaviour.
module tb_pwm_alarm_ctrl;

    localparam int TD  = 4;
    localparam int ONT = 3;
    localparam int OFT = 2;
    localparam int SNT = 5;
    localparam int RS  = 30;
    localparam int DM  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] manual_duty = '0;
    logic       trigger = 1'b0;
    logic       ack = 1'b0;
    logic       snooze = 1'b0;
    logic [6:0] duty_cmd;
    logic       alarm_active;
    logic [1:0] state;
    logic [7:0] burst_cnt;

    int total = 0;
    int passed = 0;

    int m_state, m_duty, m_burst, m_level, m_remain;
    bit m_trig_prev;

    pwm_alarm_ctrl #(
        .DUTY_MAX(DM), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFT),
        .SNOOZE_TICKS(SNT), .RAMP_STEP(RS)
    ) dut (
        .clk(clk), .rst(rst), .manual_duty(manual_duty), .trigger(trigger),
        .ack(ack), .snooze(snooze), .duty_cmd(duty_cmd),
        .alarm_active(alarm_active), .state(state), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_state = 0; m_duty = 0; m_burst = 0; m_level = 0; m_remain = 0;
        m_trig_prev = 1'b0;
    endfunction

    // Each alarm phase is a countdown of N*TD clocks from its entry edge.
    function automatic void model_clk();
        int cm;
        bit rise;
        cm = (int'(manual_duty) > DM) ? DM : int'(manual_duty);
        rise = trigger && !m_trig_prev;
        m_trig_prev = trigger;
        if (m_state == 0) begin
            m_duty = cm;
            if (rise && !ack) begin
                m_state = 1; m_level = RS; m_duty = RS; m_burst = 1; m_remain = ONT * TD;
            end
        end else if (ack) begin
            m_state = 0; m_duty = cm; m_level = 0; m_burst = 0;
        end else if (snooze && m_state != 3) begin
            m_state = 3; m_duty = 0; m_remain = SNT * TD;
        end else begin
            m_remain--;
            if (m_remain == 0) begin
                if (m_state == 1) begin
                    m_state = 2; m_duty = 0; m_remain = OFT * TD;
                end else begin
                    m_level = (m_state == 3) ? RS : ((m_level + RS > DM) ? DM : m_level + RS);
                    m_state = 1; m_duty = m_level; m_remain = ONT * TD;
                    m_burst = (m_burst >= 255) ? 255 : m_burst + 1;
                end
            end
        end
    endfunction

    function automatic logic [17:0] model_vec();
        return {2'(m_state), (m_state != 0), 7'(m_duty), 8'(m_burst)};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {state, alarm_active, duty_cmd, burst_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_clk();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #3;
        model_reset();
        total++;
        if (dut_vec() !== 18'd0) $display("[TB] FAIL reset_async: got %h want %h", dut_vec(), 18'd0);
        else passed++;
        step();
        step();
        rst = 1'b0;
        step();
        total++;
        if (dut_vec() !== model_vec()) $display("[TB] FAIL reset_release: got %h want %h", dut_vec(), model_vec());
        else passed++;
    endtask

    task automatic test_idle_passthrough();
        manual_duty = 7'd45;
        step();
        total++;
        if (dut_vec() !== {2'd0, 1'b0, 7'd45, 8'd0}) $display("[TB] FAIL idle_45: got %h want %h", dut_vec(), {2'd0, 1'b0, 7'd45, 8'd0});
        else passed++;
        manual_duty = 7'd120;
        step();
        total++;
        if (dut_vec() !== {2'd0, 1'b0, 7'd100, 8'd0}) $display("[TB] FAIL idle_clamp: got %h want %h", dut_vec(), {2'd0, 1'b0, 7'd100, 8'd0});
        else passed++;
        for (int i = 0; i < 8; i++) begin
            manual_duty = 7'($urandom_range(0, 127));
            step();
            total++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL idle_rand: got %h want %h", dut_vec(), model_vec());
            else passed++;
        end
    endtask

    task automatic test_ramp();
        int on_duty[$];
        int want[5] = '{30, 60, 90, 100, 100};
        logic [1:0] prev;
        prev = state;
        trigger = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            total++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL ramp cyc %0d: got %h want %h", c, dut_vec(), model_vec());
            else passed++;
            if (state == 2'd1 && prev != 2'd1) on_duty.push_back(int'(duty_cmd));
            prev = state;
        end
        total++;
        if (on_duty.size() != 5) $display("[TB] FAIL ramp_bursts: got %0d want 5", on_duty.size());
        else passed++;
        for (int i = 0; i < 5 && i < on_duty.size(); i++) begin
            total++;
            if (on_duty[i] != want[i]) $display("[TB] FAIL ramp_duty %0d: got %0d want %0d", i, on_duty[i], want[i]);
            else passed++;
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        trigger = 1'b0;
        step();
        total++;
        if (dut_vec() !== model_vec()) $display("[TB] FAIL ramp_ack: got %h want %h", dut_vec(), model_vec());
        else passed++;
    endtask

    task automatic test_snooze();
        int n;
        trigger = 1'b1;
        for (int c = 0; c < 24; c++) step();
        snooze = 1'b1;
        step();
        total++;
        if (state !== 2'd3 || duty_cmd !== 7'd0) $display("[TB] FAIL snooze_enter: got st=%0d duty=%0d want st=3 duty=0", state, duty_cmd);
        else passed++;
        n = 0;
        while (state == 2'd3 && n < 40) begin
            if (n == 10) snooze = 1'b0;
            step();
            n++;
            total++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL snooze cyc %0d: got %h want %h", n, dut_vec(), model_vec());
            else passed++;
        end
        snooze = 1'b0;
        total++;
        if (n != 20 || duty_cmd !== 7'd30 || burst_cnt !== 8'd3)
            $display("[TB] FAIL snooze_exit: got len=%0d duty=%0d burst=%0d want len=20 duty=30 burst=3", n, duty_cmd, burst_cnt);
        else passed++;
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_priority();
        manual_duty = 7'd77;
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        for (int c = 0; c < 15; c++) step();
        ack = 1'b1;
        snooze = 1'b1;
        step();
        ack = 1'b0;
        snooze = 1'b0;
        total++;
        if (dut_vec() !== {2'd0, 1'b0, 7'd77, 8'd0}) $display("[TB] FAIL prio_ack: got %h want %h", dut_vec(), {2'd0, 1'b0, 7'd77, 8'd0});
        else passed++;
        for (int c = 0; c < 30; c++) begin
            step();
            total++;
            if (dut_vec() !== model_vec() || state !== 2'd0) $display("[TB] FAIL prio_hold cyc %0d: got %h want %h", c, dut_vec(), model_vec());
            else passed++;
        end
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        step();
        total++;
        if (dut_vec() !== {2'd1, 1'b1, 7'd30, 8'd1}) $display("[TB] FAIL prio_restart: got %h want %h", dut_vec(), {2'd1, 1'b1, 7'd30, 8'd1});
        else passed++;
    endtask

    task automatic test_retrigger();
        for (int c = 0; c < 45; c++) begin
            trigger = ~trigger;
            step();
            total++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL retrig cyc %0d: got %h want %h", c, dut_vec(), model_vec());
            else passed++;
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        snooze = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (state !== 2'd0 || dut_vec() !== model_vec()) $display("[TB] FAIL idle_snooze: got %h want %h", dut_vec(), model_vec());
            else passed++;
        end
        snooze = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            manual_duty = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) trigger = ~trigger;
            ack = ($urandom_range(0, 59) == 0);
            snooze = ($urandom_range(0, 39) == 0);
            step();
            total++;
            if (dut_vec() !== model_vec()) $display("[TB] FAIL random cyc %0d: got %h want %h", c, dut_vec(), model_vec());
            else passed++;
        end
        ack = 1'b0;
        snooze = 1'b0;
    endtask

    task automatic test_async_reset();
        ack = 1'b1;
        step();
        ack = 1'b0;
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        for (int c = 0; c < 5; c++) step();
        #3 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (dut_vec() !== 18'd0) $display("[TB] FAIL async_reset: got %h want %h", dut_vec(), 18'd0);
        else passed++;
        trigger = 1'b0;
        step();
        rst = 1'b0;
        manual_duty = 7'd45;
        step();
        total++;
        if (dut_vec() !== {2'd0, 1'b0, 7'd45, 8'd0}) $display("[TB] FAIL post_reset_45: got %h want %h", dut_vec(), {2'd0, 1'b0, 7'd45, 8'd0});
        else passed++;
        manual_duty = 7'd120;
        step();
        total++;
        if (dut_vec() !== {2'd0, 1'b0, 7'd100, 8'd0}) $display("[TB] FAIL post_reset_clamp: got %h want %h", dut_vec(), {2'd0, 1'b0, 7'd100, 8'd0});
        else passed++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_passthrough();
        test_ramp();
        test_snooze();
        test_priority();
        test_retrigger();
        test_random();
        test_async_reset();
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
